// File: rtl/cmp_window_stats.sv
// Window statistics over a stream of comparator verdicts.
// Counts gt/eq/lt per window and tracks the largest winner.
module cmp_window_stats #(
  parameter int WIN = 8,
  parameter int CW  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    a,
  input  logic [3:0]    b,
  input  logic [2:0]    y,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] gt_cnt,
  output logic [CW-1:0] eq_cnt,
  output logic [CW-1:0] lt_cnt,
  output logic [3:0]    max_win,
  output logic          err,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

  localparam logic [CW-1:0] LAST = CW'(WIN - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  state_t        state_q, state_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [CW-1:0] gt_q, gt_d;
  logic [CW-1:0] eq_q, eq_d;
  logic [CW-1:0] lt_q, lt_d;
  logic [3:0]    max_q, max_d;
  logic          err_q, err_d;
  logic [3:0]    winner;
  logic          upd;
  logic          clr;
  logic          acc;

  assign acc = (state_q == ACCUM) && in_valid;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gt_d    = gt_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    max_d   = max_q;
    err_d   = err_q;
    winner  = a;
    upd     = 1'b0;
    clr     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACCUM;
          clr     = 1'b1;
        end
      end
      ACCUM: begin
        if (acc) begin
          idx_d = idx_q + ONE;
          if (idx_q == LAST) state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = start ? ACCUM : IDLE;
          clr     = start;
        end
      end
      default: state_d = IDLE;
    endcase
    if (acc) begin
      case (y)
        3'b100: begin
          gt_d = gt_q + ONE;
          upd  = 1'b1;
        end
        3'b010: begin
          eq_d = eq_q + ONE;
          upd  = 1'b1;
        end
        3'b001: begin
          lt_d   = lt_q + ONE;
          winner = b;
          upd    = 1'b1;
        end
        default: err_d = 1'b1;
      endcase
      if (upd && (winner > max_q)) max_d = winner;
    end
    if (clr) begin
      idx_d = '0;
      gt_d  = '0;
      eq_d  = '0;
      lt_d  = '0;
      max_d = '0;
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      gt_q    <= '0;
      eq_q    <= '0;
      lt_q    <= '0;
      max_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      max_q   <= max_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign gt_cnt    = gt_q;
  assign eq_cnt    = eq_q;
  assign lt_cnt    = lt_q;
  assign max_win   = max_q;
  assign err       = err_q;

endmodule

// File: tb/tb_cmp_window_stats.sv
// Bench for cmp_window_stats: four instances with WIN=3,4,1,8.
// Window tables plus hand-written reset/hold sequences.
module tb_cmp_window_stats;

  logic clk;
  logic rst_n;
  logic       st[4], iv[4], orr[4];
  logic [3:0] av[4], bv[4];
  logic [2:0] yv[4];
  logic       ir[4], ov[4], er[4], bz[4];
  logic [3:0] gc[4], ec[4], lc[4], mw[4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int W = (g == 0) ? 3 : (g == 1) ? 4 : (g == 2) ? 1 : 8;
    cmp_window_stats #(.WIN(W), .CW(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(st[g]),
      .in_valid(iv[g]), .in_ready(ir[g]),
      .a(av[g]), .b(bv[g]), .y(yv[g]),
      .out_valid(ov[g]), .out_ready(orr[g]),
      .gt_cnt(gc[g]), .eq_cnt(ec[g]), .lt_cnt(lc[g]),
      .max_win(mw[g]), .err(er[g]), .busy(bz[g])
    );
  end

  typedef struct {
    int k; int gt; int eq; int lt; int mw; int err;
  } exp_t;

  typedef struct {
    int k; int n; bit gaps;
    logic [7:0][3:0] a;
    logic [7:0][3:0] b;
    logic [7:0][2:0] y;
    exp_t e;
  } rec_t;

  rec_t tbl[6];
  exp_t sb[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_s(input int r, input int i,
                       input int a, input int b, input logic [2:0] y);
    tbl[r].a[i] = 4'(a);
    tbl[r].b[i] = 4'(b);
    tbl[r].y[i] = y;
  endtask

  task automatic set_e(input int r, input int k, input int n,
                       input bit gp, input int gt, input int eq,
                       input int lt, input int m, input int e);
    tbl[r].k = k; tbl[r].n = n; tbl[r].gaps = gp;
    tbl[r].e = '{k, gt, eq, lt, m, e};
  endtask

  function automatic exp_t model(input rec_t r);
    exp_t e;
    int w;
    e = '{r.k, 0, 0, 0, 0, 0};
    for (int i = 0; i < r.n; i++) begin
      w = -1;
      if (r.y[i] == 3'b100) begin e.gt++; w = r.a[i]; end
      else if (r.y[i] == 3'b010) begin e.eq++; w = r.a[i]; end
      else if (r.y[i] == 3'b001) begin e.lt++; w = r.b[i]; end
      else e.err = 1;
      if (w > e.mw) e.mw = w;
    end
    return e;
  endfunction

  task automatic start_win(input int k);
    st[k] = 1'b1;
    tick();
    st[k] = 1'b0;
    chk("start_in_ready", ir[k], 1);
    chk("start_busy", bz[k], 1);
    chk("start_cleared", gc[k] + ec[k] + lc[k] + mw[k] + er[k], 0);
  endtask

  task automatic feed(input rec_t r);
    int k;
    k = r.k;
    for (int i = 0; i < r.n; i++) begin
      iv[k] = 1'b1;
      av[k] = r.a[i]; bv[k] = r.b[i]; yv[k] = r.y[i];
      if (i == r.n - 1) sb.push_back(r.e);
      tick();
      chk("out_valid_timing", ov[k], (i == r.n - 1) ? 1 : 0);
      if (r.gaps && i < r.n - 1) begin
        iv[k] = 1'b0;
        av[k] = 4'hf; bv[k] = 4'hf; yv[k] = 3'b100;
        tick();
        tick();
        chk("gap_stall", {ov[k], ir[k]}, 1);
      end
    end
    iv[k] = 1'b0;
    chk("in_ready_drop", ir[k], 0);
  endtask

  task automatic check_out(input int k, input bit rel);
    exp_t e;
    int n;
    n = 0;
    while (!ov[k] && n < 20) begin
      tick();
      n++;
    end
    chk("out_valid_seen", ov[k], 1);
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 0, 1);
    end else begin
      e = sb.pop_front();
      chk("sb_dut", k, e.k);
      chk("gt_cnt", gc[k], e.gt);
      chk("eq_cnt", ec[k], e.eq);
      chk("lt_cnt", lc[k], e.lt);
      chk("max_win", mw[k], e.mw);
      chk("err", er[k], e.err);
    end
    if (rel) begin
      orr[k] = 1'b1;
      tick();
      orr[k] = 1'b0;
      chk("release_out_valid", ov[k], 0);
      chk("release_busy", bz[k], 0);
    end
  endtask

  initial begin
    rec_t rr;
    for (int k = 0; k < 4; k++) begin
      st[k] = 0; iv[k] = 0; orr[k] = 0;
      av[k] = 0; bv[k] = 0; yv[k] = 0;
    end
    set_e(0, 0, 3, 0, 0, 1, 2, 12, 0);
    set_s(0, 0, 10, 12, 3'b001);
    set_s(0, 1, 1, 1, 3'b010);
    set_s(0, 2, 1, 8, 3'b001);
    set_e(1, 1, 4, 0, 1, 1, 1, 15, 1);
    set_s(1, 0, 15, 0, 3'b100);
    set_s(1, 1, 3, 3, 3'b010);
    set_s(1, 2, 2, 9, 3'b001);
    set_s(1, 3, 7, 7, 3'b110);
    set_e(2, 2, 1, 0, 0, 1, 0, 0, 0);
    set_s(2, 0, 0, 0, 3'b010);
    set_e(3, 3, 8, 0, 8, 0, 0, 9, 0);
    for (int i = 0; i < 8; i++) set_s(3, i, i + 2, 3, 3'b100);
    set_e(4, 0, 3, 1, 1, 0, 1, 9, 1);
    set_s(4, 0, 5, 9, 3'b001);
    set_s(4, 1, 9, 5, 3'b100);
    set_s(4, 2, 4, 4, 3'b000);
    set_e(5, 3, 8, 1, 2, 2, 3, 13, 1);
    set_s(5, 0, 3, 14, 3'b100);
    set_s(5, 1, 14, 2, 3'b001);
    set_s(5, 2, 6, 6, 3'b010);
    set_s(5, 3, 1, 11, 3'b001);
    set_s(5, 4, 12, 3, 3'b111);
    set_s(5, 5, 7, 2, 3'b100);
    set_s(5, 6, 2, 2, 3'b010);
    set_s(5, 7, 5, 13, 3'b001);

    rst_n = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("reset_ctl", {ir[k], ov[k], bz[k], er[k]}, 0);
      chk("reset_cnt", gc[k] + ec[k] + lc[k] + mw[k], 0);
    end
    rst_n = 1'b1;
    tick();

    for (int r = 0; r < 6; r++) begin
      start_win(tbl[r].k);
      feed(tbl[r]);
      check_out(tbl[r].k, 1'b1);
    end

    start_win(1);
    feed(tbl[1]);
    for (int c = 0; c < 5; c++) begin
      st[1] = (c == 2);
      tick();
      chk("hold_out_valid", ov[1], 1);
      chk("hold_in_ready", ir[1], 0);
      chk("hold_frozen", {gc[1], ec[1], lc[1], mw[1]}, 16'h111f);
    end
    check_out(1, 1'b0);
    st[1] = 1'b1;
    orr[1] = 1'b1;
    tick();
    st[1] = 1'b0;
    orr[1] = 1'b0;
    chk("b2b_in_ready", ir[1], 1);
    chk("b2b_out_valid", ov[1], 0);
    chk("b2b_cleared", gc[1] + ec[1] + lc[1] + mw[1] + er[1], 0);
    rr = tbl[1];
    rr.a[0] = 1; rr.b[0] = 2; rr.y[0] = 3'b001;
    rr.a[1] = 2; rr.b[1] = 1; rr.y[1] = 3'b100;
    rr.a[2] = 4; rr.b[2] = 4; rr.y[2] = 3'b010;
    rr.a[3] = 0; rr.b[3] = 0; rr.y[3] = 3'b010;
    rr.e = '{1, 1, 2, 1, 4, 0};
    feed(rr);
    check_out(1, 1'b1);

    start_win(3);
    for (int i = 0; i < 3; i++) begin
      iv[3] = 1'b1; av[3] = 9; bv[3] = 1; yv[3] = 3'b100;
      tick();
    end
    iv[3] = 1'b0;
    chk("pre_reset_gt", gc[3], 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_ctl", {ir[3], ov[3], bz[3], er[3]}, 0);
    chk("async_rst_cnt", {gc[3], mw[3]}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    start_win(3);
    feed(tbl[3]);
    check_out(3, 1'b1);

    rr = tbl[3];
    rr.gaps = 1;
    for (int i = 0; i < 8; i++) begin
      rr.a[i] = 4'($urandom_range(0, 15));
      rr.b[i] = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 4))
        0: rr.y[i] = 3'b100;
        1: rr.y[i] = 3'b010;
        2: rr.y[i] = 3'b001;
        default: rr.y[i] = 3'($urandom_range(0, 7));
      endcase
    end
    rr.e = model(rr);
    start_win(3);
    feed(rr);
    check_out(3, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
